// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU) for the EX stage; produces {remainder, quotient}.
// WIDTH+1 cycles from start to ready (1 for a zero divisor); stall_o holds F/D/E until the ready cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o,
  output logic               dbz_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     shifted, diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_step, quo_step, rem_fix, quo_fix;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;

  // One restoring step; the quotient accumulates into the dividend register as it shifts out.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    qbit     = ~diff[WIDTH];
    rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {dvd_q[WIDTH-2:0], qbit};
    quo_fix  = neg_q_q ? -quo_step : quo_step;
    rem_fix  = neg_r_q ? -rem_step : rem_step;
  end

  always_comb begin
    op1_neg = signed_i & opdata1_i[WIDTH-1];
    op2_neg = signed_i & opdata2_i[WIDTH-1];
    op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    op2_abs = op2_neg ? -opdata2_i : opdata2_i;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    stall_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          stall_o = 1'b1;
          if (opdata2_i == '0) begin
            state_d  = DONE;
            result_d = {opdata1_i, {WIDTH{1'b1}}};
            dbz_d    = 1'b1;
          end else begin
            state_d = BUSY;
            count_d = '0;
            rem_d   = '0;
            dvd_d   = op1_abs;
            dvs_d   = op2_abs;
            neg_q_d = op1_neg ^ op2_neg;
            neg_r_d = op1_neg;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d   = rem_step;
          dvd_d   = quo_step;
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = {rem_fix, quo_fix};
            dbz_d    = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == DONE);
  assign dbz_o    = (state_q == DONE) & dbz_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage; executes DIV/DIVU.
- Drives the EX-stage divider stall into the hazard unit (div_stallE). That signal stalls F/D/E while a division runs.
- Produces {remainder, quotient} for the HI/LO write.
- Clocked on clk. Reset is synchronous and active-high, on rst.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  DIV/DIVU present in E; held high while the instruction is stalled in E
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  WIDTH  dividend (rs)
- opdata2_i  input  WIDTH  divisor (rt)
- annul_i  input  1  abort the in-flight division (pipeline flush)
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
- ready_o  output  1  result valid; one-cycle pulse
- stall_o  output  1  to hazard unit as div_stallE
- dbz_o  output  1  divide-by-zero flag, valid with ready_o

Behaviour:
- Reset values:
  - state = IDLE
  - result_o = 0, ready_o = 0, dbz_o = 0, stall_o = 0
  - internal count = 0
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If start_i & ~annul_i & divisor != 0: latch |dividend|, |divisor| (absolute values only when signed_i=1), latch signed_i and both operand signs, clear partial remainder, count = 0, go to BUSY.
  - If start_i & ~annul_i & divisor == 0: go to DONE with quotient = all ones, remainder = opdata1_i, dbz_o = 1.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle do one restoring step: shift {rem, dividend} left 1; subtract the divisor if rem >= divisor; the quotient bit is the result of that compare. count increments.
  - After the step with count == WIDTH-1, go to DONE and register the sign-fixed result.
  - annul_i = 1 in any BUSY cycle: go to IDLE next cycle; no ready_o; result_o unchanged.
- DONE:
  - ready_o = 1 for exactly this cycle, then go to IDLE unconditionally.
  - start_i seen in DONE does not retrigger.
- stall_o (combinational) = (IDLE & start_i & ~annul_i) | BUSY. It is 0 in DONE, so the instruction leaves E in the ready cycle.
- Latency for a nonzero divisor (start seen in IDLE at cycle 0):
  - stall_o high cycles 0..WIDTH (WIDTH+1 cycles).
  - ready_o in cycle WIDTH+1.
- Latency for a zero divisor: stall_o high in cycle 0 only; ready_o in cycle 1.
- Sign fixup (signed_i = 1 only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^(W-1) / -1 gives quotient 0x80000000, remainder 0 (no trap).
- Operands are captured at start only; input changes during BUSY are ignored.
- result_o holds its last value until the next DONE.
- Back-to-back divides: a start_i in the cycle after DONE (state IDLE) begins a new operation normally.
- rst in any state forces the reset values on the next edge; no ready_o is produced for the aborted operation.

Test Plan:
- DIVU 100 / 7, start at cycle 0 → stall_o high cycles 0..32, low at 33; ready_o at cycle 33 only; result_o = {0x00000002, 0x0000000E}; dbz_o = 0.
- DIV -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / -2 → {0x00000001, 0xFFFFFFFD}. DIVU 0xFFFFFFF9 / 2 → {0x00000001, 0x7FFFFFFC}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}, ready_o at cycle 33.
- DIVU 5 / 0 → stall_o high cycle 0 only; ready_o and dbz_o at cycle 1; result_o = {0x00000005, 0xFFFFFFFF}.
- annul_i pulsed at cycle 10 of 100/7 → stall_o low from cycle 11, no ready_o, state IDLE. A fresh 9/3 then gives {0, 3} 33 cycles after its start.
- rst at cycle 15 mid-operation → all outputs 0 next cycle. Back-to-back 20/3 then 20/6 with start_i held → two ready pulses 34 cycles apart; results {2, 6} then {2, 3}.
